// File: rtl/counter_sequencer.sv
// Latches plus/minus counter requests, grants the lowest pending counter once per stb; grant one cycle after stb.
// No backpressure: grants wait for done, and a request that repeats a pending direction is dropped and flagged.
module counter_sequencer #(
  parameter int              NREQ  = 8,
  parameter int              IDX_W = 3,
  parameter logic [NREQ-1:0] CHAIN = NREQ'(1)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             stb,
  input  logic             inhibit,
  input  logic [NREQ-1:0]  plus_req,
  input  logic [NREQ-1:0]  minus_req,
  input  logic             done,
  input  logic             ovf,
  output logic             grant_vld,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_minus,
  output logic             busy,
  output logic [NREQ-1:0]  pend_p,
  output logic [NREQ-1:0]  pend_m,
  output logic             dropped
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT} state_t;

  state_t           state, state_nxt;
  logic [NREQ-1:0]  pend_any;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_minus;
  logic             go;
  logic             chain_fire;
  logic [NREQ-1:0]  clr_p, clr_m;
  logic [NREQ-1:0]  inj_p, inj_m;
  logic [NREQ-1:0]  nxt_p, nxt_m;
  logic [NREQ-1:0]  drop_vec;

  assign pend_any   = pend_p | pend_m;
  assign go         = (state == S_IDLE) && stb && !inhibit && (|pend_any);
  assign chain_fire = (state == S_WAIT) && done && ovf;

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    sel_idx   = '0;
    sel_minus = 1'b0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (pend_any[i]) begin
        sel_idx   = IDX_W'(i);
        sel_minus = pend_m[i];
      end
    end
  end

  always_comb begin
    clr_p = '0;
    clr_m = '0;
    inj_p = '0;
    inj_m = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (go && sel_idx == IDX_W'(i)) begin
        clr_p[i] = !sel_minus;
        clr_m[i] = sel_minus;
      end
    end
    for (int i = 0; i < NREQ-1; i++) begin
      if (chain_fire && CHAIN[i] && grant_idx == IDX_W'(i)) begin
        inj_p[i+1] = !grant_minus;
        inj_m[i+1] = grant_minus;
      end
    end
  end

  // Grant clear is applied before new requests so a same-cycle request re-pends.
  always_comb begin
    logic bp, bm, rp, rm;
    nxt_p    = '0;
    nxt_m    = '0;
    drop_vec = '0;
    for (int i = 0; i < NREQ; i++) begin
      bp = pend_p[i] & ~clr_p[i];
      bm = pend_m[i] & ~clr_m[i];
      rp = plus_req[i]  | inj_p[i];
      rm = minus_req[i] | inj_m[i];
      nxt_p[i] = bp;
      nxt_m[i] = bm;
      if (rp && !rm) begin
        if (bm)      nxt_m[i]    = 1'b0;
        else if (bp) drop_vec[i] = 1'b1;
        else         nxt_p[i]    = 1'b1;
      end else if (rm && !rp) begin
        if (bp)      nxt_p[i]    = 1'b0;
        else if (bm) drop_vec[i] = 1'b1;
        else         nxt_m[i]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go) state_nxt = S_GRANT;
      S_GRANT: state_nxt = S_WAIT;
      S_WAIT:  if (done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant_vld = (state == S_GRANT);
    busy      = (state != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      pend_p      <= '0;
      pend_m      <= '0;
      dropped     <= 1'b0;
      grant_idx   <= '0;
      grant_minus <= 1'b0;
    end else begin
      pend_p  <= nxt_p;
      pend_m  <= nxt_m;
      dropped <= |drop_vec;
      if (go) begin
        grant_idx   <= sel_idx;
        grant_minus <= sel_minus;
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: priority, cancel/drop, overflow chaining, inhibit and reset.
module tb_counter_sequencer;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  logic             clock = 1'b0;
  logic             rst, stb, inhibit, done, ovf;
  logic [NREQ-1:0]  plus_req, minus_req;
  logic             grant_vld, grant_minus, busy, dropped;
  logic [IDX_W-1:0] grant_idx;
  logic [NREQ-1:0]  pend_p, pend_m;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  counter_sequencer #(.NREQ(NREQ), .IDX_W(IDX_W), .CHAIN(8'b0000_0001)) dut (
    .clock       (clock),
    .rst         (rst),
    .stb         (stb),
    .inhibit     (inhibit),
    .plus_req    (plus_req),
    .minus_req   (minus_req),
    .done        (done),
    .ovf         (ovf),
    .grant_vld   (grant_vld),
    .grant_idx   (grant_idx),
    .grant_minus (grant_minus),
    .busy        (busy),
    .pend_p      (pend_p),
    .pend_m      (pend_m),
    .dropped     (dropped)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs driven 1ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // From IDLE with something pending: stb, check the grant, then finish it.
  task automatic grant_and_finish(input string tag, input int idx, input logic minus,
                                  input logic ov);
    stb = 1'b1; step(); stb = 1'b0;
    check({tag, "_vld"},   32'(grant_vld),   32'd1);
    check({tag, "_idx"},   32'(grant_idx),   32'(idx));
    check({tag, "_minus"}, 32'(grant_minus), 32'(minus));
    step();
    done = 1'b1; ovf = ov; step(); done = 1'b0; ovf = 1'b0;
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; stb = 1'b1; inhibit = 1'b0; done = 1'b0; ovf = 1'b0;
    plus_req = 8'hFF; minus_req = 8'h00;
    step(); step();
    check("rst_vld",   32'(grant_vld),   32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_idx",   32'(grant_idx),   32'd0);
    check("rst_minus", 32'(grant_minus), 32'd0);
    check("rst_pp",    32'(pend_p),      32'd0);
    check("rst_pm",    32'(pend_m),      32'd0);
    check("rst_drop",  32'(dropped),     32'd0);
    rst = 1'b0; stb = 1'b0; plus_req = 8'h00;
    step();
    check("idle_pp", 32'(pend_p), 32'd0);
    check("idle_vld", 32'(grant_vld), 32'd0);

    // Priority: lowest index first, one grant per stb
    plus_req = 8'hA0; step(); plus_req = 8'h00;
    check("prio_pend", 32'(pend_p), 32'hA0);
    stb = 1'b1; step(); stb = 1'b0;
    check("prio_vld",  32'(grant_vld), 32'd1);
    check("prio_idx",  32'(grant_idx), 32'd5);
    check("prio_min",  32'(grant_minus), 32'd0);
    check("prio_busy", 32'(busy), 32'd1);
    check("prio_pp",   32'(pend_p), 32'h80);
    step();
    check("prio_one_grant", 32'(grant_vld), 32'd0);
    check("prio_wait_busy", 32'(busy), 32'd1);
    done = 1'b1; step(); done = 1'b0;
    check("prio_done_busy", 32'(busy), 32'd0);
    grant_and_finish("prio2", 7, 1'b0, 1'b0);
    check("prio2_pp", 32'(pend_p), 32'd0);

    // Cancel and drop
    plus_req = 8'h04; step(); plus_req = 8'h00;
    minus_req = 8'h04; step(); minus_req = 8'h00;
    check("cancel_pp", 32'(pend_p), 32'd0);
    check("cancel_pm", 32'(pend_m), 32'd0);
    stb = 1'b1; step(); stb = 1'b0;
    check("cancel_nogrant", 32'(grant_vld), 32'd0);
    plus_req = 8'h08; step();
    check("drop_first", 32'(dropped), 32'd0);
    step(); plus_req = 8'h00;
    check("drop_pulse", 32'(dropped), 32'd1);
    check("drop_pp",    32'(pend_p),  32'h08);
    step();
    check("drop_once",  32'(dropped), 32'd0);
    grant_and_finish("drop_gr", 3, 1'b0, 1'b0);

    // Request to the granted bit during GRANT re-pends without a drop
    plus_req = 8'h40; step(); plus_req = 8'h00;
    stb = 1'b1; step(); stb = 1'b0;
    check("repend_clr", 32'(pend_p), 32'd0);
    plus_req = 8'h40; step(); plus_req = 8'h00;
    check("repend_pp",   32'(pend_p),  32'h40);
    check("repend_drop", 32'(dropped), 32'd0);
    done = 1'b1; step(); done = 1'b0;
    grant_and_finish("repend_gr", 6, 1'b0, 1'b0);

    // Overflow chain from counter 0 into counter 1
    plus_req = 8'h01; step(); plus_req = 8'h00;
    grant_and_finish("chain_p", 0, 1'b0, 1'b1);
    check("chain_pp", 32'(pend_p), 32'h02);
    grant_and_finish("chain_p1", 1, 1'b0, 1'b1);
    check("chain_p1_pp", 32'(pend_p), 32'd0);
    minus_req = 8'h01; step(); minus_req = 8'h00;
    grant_and_finish("chain_m", 0, 1'b1, 1'b1);
    check("chain_pm", 32'(pend_m), 32'h02);
    grant_and_finish("chain_m1", 1, 1'b1, 1'b0);
    plus_req = 8'h01; step(); plus_req = 8'h00;
    grant_and_finish("nochain", 0, 1'b0, 1'b0);
    check("nochain_pp", 32'(pend_p), 32'd0);

    // Inhibit blocks new grants only; stb in WAIT ignored
    plus_req = 8'h10; step(); plus_req = 8'h00;
    inhibit = 1'b1; stb = 1'b1; step(); stb = 1'b0;
    check("inh_nogrant", 32'(grant_vld), 32'd0);
    check("inh_busy",    32'(busy),      32'd0);
    inhibit = 1'b0; stb = 1'b1; step(); stb = 1'b0;
    check("inh_gr_vld", 32'(grant_vld), 32'd1);
    check("inh_gr_idx", 32'(grant_idx), 32'd4);
    plus_req = 8'h20; step(); plus_req = 8'h00;
    inhibit = 1'b1; step();
    check("inh_wait_busy", 32'(busy), 32'd1);
    inhibit = 1'b0; stb = 1'b1; step(); stb = 1'b0;
    check("wait_stb_vld",  32'(grant_vld), 32'd0);
    check("wait_stb_busy", 32'(busy),      32'd1);
    done = 1'b1; step(); done = 1'b0;
    check("inh_done_busy", 32'(busy),   32'd0);
    check("inh_done_pp",   32'(pend_p), 32'h20);
    grant_and_finish("inh_drain", 5, 1'b0, 1'b0);

    // Reset mid-operation
    plus_req = 8'h03; step(); plus_req = 8'h00;
    stb = 1'b1; step(); stb = 1'b0;
    step();
    check("mid_busy", 32'(busy),   32'd1);
    check("mid_pp",   32'(pend_p), 32'h02);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_busy", 32'(busy),   32'd0);
    check("mid_rst_pp",   32'(pend_p), 32'd0);
    done = 1'b1; ovf = 1'b1; step(); done = 1'b0; ovf = 1'b0;
    check("mid_done_busy", 32'(busy),      32'd0);
    check("mid_done_vld",  32'(grant_vld), 32'd0);
    check("mid_done_pp",   32'(pend_p),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
